// File: rtl/int_reservation_station.sv
// int_reservation_station: integer-unit reservation station.
// Buffers renamed integer ops and snoops the CDB for missing operands.
// Issues the oldest fully-ready op to the ALU.
// Squashes speculative entries when the branch unit reports a mispredict.
// Optional feature macro: RS_CDB_BYPASS_EN. When it is defined, an operand
// broadcast on the CDB this cycle counts as ready and is forwarded straight
// to o_alu_A/B.
module int_reservation_station #(
    parameter int NUM_ENTRY         = 4,
    parameter int BW_TAG            = 3,
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_OPCODE_INT     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_iq_valid,
    output logic                           i_iq_ready,
    input  logic [BW_OPCODE_INT-1:0]       i_iq_opcode,
    input  logic [2*BW_TAG-1:0]            i_iq_Q_flatten,
    input  logic [2*BW_PROCESSOR_DATA-1:0] i_iq_V_flatten,
    input  logic [BW_TAG-1:0]              i_iq_tag,
    input  logic                           i_iq_speculation,
    input  logic                           i_cdb_valid,
    input  logic [BW_TAG-1:0]              i_cdb_tag,
    input  logic [BW_PROCESSOR_DATA-1:0]   i_cdb_data,
    input  logic                           i_branch_valid,
    input  logic                           i_branch_flush,
    output logic                           o_alu_valid,
    input  logic                           o_alu_ready,
    output logic [BW_OPCODE_INT-1:0]       o_alu_opcode,
    output logic [BW_PROCESSOR_DATA-1:0]   o_alu_A,
    output logic [BW_PROCESSOR_DATA-1:0]   o_alu_B,
    output logic [BW_TAG-1:0]              o_alu_tag
);

    localparam int AW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

    // Per-entry state
    logic [NUM_ENTRY-1:0]         busy_r;
    logic [NUM_ENTRY-1:0]         spec_r;
    logic [BW_OPCODE_INT-1:0]     opcode_r [NUM_ENTRY];
    logic [BW_TAG-1:0]            q0_r     [NUM_ENTRY];
    logic [BW_TAG-1:0]            q1_r     [NUM_ENTRY];
    logic [BW_PROCESSOR_DATA-1:0] v0_r     [NUM_ENTRY];
    logic [BW_PROCESSOR_DATA-1:0] v1_r     [NUM_ENTRY];
    logic [BW_TAG-1:0]            tag_r    [NUM_ENTRY];
    logic [AW-1:0]                age_r    [NUM_ENTRY];

    // Combinational helpers
    logic                         flush_s;
    logic                         resolve_s;
    logic [AW-1:0]                free_idx_s;
    logic [NUM_ENTRY-1:0]         hit0_s;
    logic [NUM_ENTRY-1:0]         hit1_s;
    logic [NUM_ENTRY-1:0]         elig_s;
    logic                         sel_found_s;
    logic [AW-1:0]                sel_idx_s;
    logic [AW-1:0]                sel_age_s;
    logic                         issue_fire_s;
    logic                         dispatch_fire_s;
    logic [NUM_ENTRY-1:0]         keep_s;
    logic [AW:0]                  keep_cnt_s;
    logic [AW-1:0]                new_age_s [NUM_ENTRY];
    logic [BW_TAG-1:0]            dq0_s;
    logic [BW_TAG-1:0]            dq1_s;
    logic [BW_PROCESSOR_DATA-1:0] dv0_s;
    logic [BW_PROCESSOR_DATA-1:0] dv1_s;
    logic                         dhit0_s;
    logic                         dhit1_s;

    // Branch outcome decode
    assign flush_s   = i_branch_valid && i_branch_flush;
    assign resolve_s = i_branch_valid && !i_branch_flush;

    // Ready depends only on registered occupancy: no ready-through on issue
    assign i_iq_ready = ~(&busy_r);

    // Lowest-index free slot (scan downward so the lowest index wins)
    always_comb begin
        free_idx_s = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            free_idx_s = busy_r[i] ? free_idx_s : AW'(i);
        end
    end

    // CDB tag match per entry operand, and issue eligibility
    always_comb begin
        hit0_s = '0;
        hit1_s = '0;
        elig_s = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            hit0_s[i] = busy_r[i] && i_cdb_valid && (q0_r[i] != '0) && (q0_r[i] == i_cdb_tag);
            hit1_s[i] = busy_r[i] && i_cdb_valid && (q1_r[i] != '0) && (q1_r[i] == i_cdb_tag);
`ifdef RS_CDB_BYPASS_EN
            elig_s[i] = busy_r[i]
                        && ((q0_r[i] == '0) || hit0_s[i])
                        && ((q1_r[i] == '0) || hit1_s[i])
                        && !(spec_r[i] && flush_s);
`else
            elig_s[i] = busy_r[i]
                        && (q0_r[i] == '0)
                        && (q1_r[i] == '0)
                        && !(spec_r[i] && flush_s);
`endif
        end
    end

    // Oldest-first selection among eligible entries (ages are unique)
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_age_s   = '1;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            sel_idx_s   = (elig_s[i] && (!sel_found_s || (age_r[i] < sel_age_s))) ? AW'(i)   : sel_idx_s;
            sel_age_s   = (elig_s[i] && (!sel_found_s || (age_r[i] < sel_age_s))) ? age_r[i] : sel_age_s;
            sel_found_s = sel_found_s || elig_s[i];
        end
    end

    // Issue port drive; data outputs are zero while nothing is selected
    always_comb begin
        o_alu_valid  = 1'b0;
        o_alu_opcode = '0;
        o_alu_A      = '0;
        o_alu_B      = '0;
        o_alu_tag    = '0;
        if (sel_found_s) begin
            o_alu_valid  = 1'b1;
            o_alu_opcode = opcode_r[sel_idx_s];
            o_alu_tag    = tag_r[sel_idx_s];
`ifdef RS_CDB_BYPASS_EN
            o_alu_A      = (q0_r[sel_idx_s] != '0) ? i_cdb_data : v0_r[sel_idx_s];
            o_alu_B      = (q1_r[sel_idx_s] != '0) ? i_cdb_data : v1_r[sel_idx_s];
`else
            o_alu_A      = v0_r[sel_idx_s];
            o_alu_B      = v1_r[sel_idx_s];
`endif
        end else begin
            o_alu_valid  = 1'b0;
        end
    end

    assign issue_fire_s    = o_alu_valid && o_alu_ready;
    assign dispatch_fire_s = i_iq_valid && i_iq_ready && !(i_iq_speculation && flush_s);

    // Survivors after issue/flush, and their recompacted age ranks
    always_comb begin
        keep_s     = '0;
        keep_cnt_s = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            keep_s[i] = busy_r[i]
                        && !(issue_fire_s && (sel_idx_s == AW'(i)))
                        && !(flush_s && spec_r[i]);
        end
        for (int i = 0; i < NUM_ENTRY; i++) begin
            keep_cnt_s   = keep_cnt_s + {{AW{1'b0}}, keep_s[i]};
            new_age_s[i] = '0;
            for (int j = 0; j < NUM_ENTRY; j++) begin
                new_age_s[i] = new_age_s[i]
                               + {{(AW-1){1'b0}}, (keep_s[j] && (age_r[j] < age_r[i]))};
            end
        end
    end

    // Dispatch operands with same-cycle CDB capture
    always_comb begin
        dq0_s   = i_iq_Q_flatten[BW_TAG-1:0];
        dq1_s   = i_iq_Q_flatten[2*BW_TAG-1:BW_TAG];
        dv0_s   = i_iq_V_flatten[BW_PROCESSOR_DATA-1:0];
        dv1_s   = i_iq_V_flatten[2*BW_PROCESSOR_DATA-1:BW_PROCESSOR_DATA];
        dhit0_s = i_cdb_valid && (dq0_s != '0) && (dq0_s == i_cdb_tag);
        dhit1_s = i_cdb_valid && (dq1_s != '0) && (dq1_s == i_cdb_tag);
        if (dhit0_s) begin
            dq0_s = '0;
            dv0_s = i_cdb_data;
        end else begin
            dq0_s = dq0_s;
        end
        if (dhit1_s) begin
            dq1_s = '0;
            dv1_s = i_cdb_data;
        end else begin
            dq1_s = dq1_s;
        end
    end

    // Entry state update: wakeup, free, age recompaction, spec clear, dispatch write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            spec_r <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                opcode_r[i] <= '0;
                q0_r[i]     <= '0;
                q1_r[i]     <= '0;
                v0_r[i]     <= '0;
                v1_r[i]     <= '0;
                tag_r[i]    <= '0;
                age_r[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                busy_r[i] <= keep_s[i];
                spec_r[i] <= keep_s[i] && spec_r[i] && !resolve_s;
                age_r[i]  <= new_age_s[i];
                if (hit0_s[i]) begin
                    q0_r[i] <= '0;
                    v0_r[i] <= i_cdb_data;
                end
                if (hit1_s[i]) begin
                    q1_r[i] <= '0;
                    v1_r[i] <= i_cdb_data;
                end
            end
            if (dispatch_fire_s) begin
                busy_r[free_idx_s]   <= 1'b1;
                spec_r[free_idx_s]   <= i_iq_speculation && !resolve_s;
                age_r[free_idx_s]    <= AW'(keep_cnt_s);
                opcode_r[free_idx_s] <= i_iq_opcode;
                tag_r[free_idx_s]    <= i_iq_tag;
                q0_r[free_idx_s]     <= dq0_s;
                q1_r[free_idx_s]     <= dq1_s;
                v0_r[free_idx_s]     <= dv0_s;
                v1_r[free_idx_s]     <= dv1_s;
            end
        end
    end

endmodule

// File: tb/tb_int_reservation_station.sv
// Scoreboard bench for int_reservation_station: stimulus pushes the expected
// issue packet; a negedge monitor pops and compares on every ALU handshake.
module tb_int_reservation_station;

`ifdef RS_CDB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_iq_valid;
    logic        i_iq_ready;
    logic [3:0]  i_iq_opcode;
    logic [5:0]  i_iq_Q_flatten;
    logic [63:0] i_iq_V_flatten;
    logic [2:0]  i_iq_tag;
    logic        i_iq_speculation;
    logic        i_cdb_valid;
    logic [2:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        i_branch_valid;
    logic        i_branch_flush;
    logic        o_alu_valid;
    logic        o_alu_ready;
    logic [3:0]  o_alu_opcode;
    logic [31:0] o_alu_A;
    logic [31:0] o_alu_B;
    logic [2:0]  o_alu_tag;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int_reservation_station dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_iq_valid       (i_iq_valid),
        .i_iq_ready       (i_iq_ready),
        .i_iq_opcode      (i_iq_opcode),
        .i_iq_Q_flatten   (i_iq_Q_flatten),
        .i_iq_V_flatten   (i_iq_V_flatten),
        .i_iq_tag         (i_iq_tag),
        .i_iq_speculation (i_iq_speculation),
        .i_cdb_valid      (i_cdb_valid),
        .i_cdb_tag        (i_cdb_tag),
        .i_cdb_data       (i_cdb_data),
        .i_branch_valid   (i_branch_valid),
        .i_branch_flush   (i_branch_flush),
        .o_alu_valid      (o_alu_valid),
        .o_alu_ready      (o_alu_ready),
        .o_alu_opcode     (o_alu_opcode),
        .o_alu_A          (o_alu_A),
        .o_alu_B          (o_alu_B),
        .o_alu_tag        (o_alu_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; single-cycle pulses return low
    task automatic step();
        @(posedge clk);
        #1;
        i_iq_valid     = 1'b0;
        i_cdb_valid    = 1'b0;
        i_branch_valid = 1'b0;
        i_branch_flush = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [2:0] q0, input logic [2:0] q1,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [2:0] tg, input logic sp);
        i_iq_valid       = 1'b1;
        i_iq_opcode      = op;
        i_iq_Q_flatten   = {q1, q0};
        i_iq_V_flatten   = {v1, v0};
        i_iq_tag         = tg;
        i_iq_speculation = sp;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] tg);
        exp_t e;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.tag = tg;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && o_alu_valid && o_alu_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got tag %0d expected no issue", o_alu_tag);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_alu_opcode, o_alu_A, o_alu_B, o_alu_tag} !== mon_e) begin
                    errors++;
                    $display("FAIL issue_packet: got op=%0h A=%0h B=%0h tag=%0d expected op=%0h A=%0h B=%0h tag=%0d",
                             o_alu_opcode, o_alu_A, o_alu_B, o_alu_tag,
                             mon_e.op, mon_e.a, mon_e.b, mon_e.tag);
                end
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        i_iq_valid       = 1'b0;
        i_iq_opcode      = 4'd0;
        i_iq_Q_flatten   = 6'd0;
        i_iq_V_flatten   = 64'd0;
        i_iq_tag         = 3'd0;
        i_iq_speculation = 1'b0;
        i_cdb_valid      = 1'b0;
        i_cdb_tag        = 3'd0;
        i_cdb_data       = 32'd0;
        i_branch_valid   = 1'b0;
        i_branch_flush   = 1'b0;
        o_alu_ready      = 1'b0;

        // Reset state
        #3;
        check("reset_iq_ready", {31'd0, i_iq_ready}, 32'd1);
        check("reset_alu_valid", {31'd0, o_alu_valid}, 32'd0);
        check("reset_alu_A", o_alu_A, 32'd0);
        check("reset_alu_tag", {29'd0, o_alu_tag}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // T1: ready operands issue next cycle, station empty after handshake
        o_alu_ready = 1'b1;
        disp(4'd1, 3'd0, 3'd0, 32'd5, 32'd7, 3'd2, 1'b0);
        expect_issue(4'd1, 32'd5, 32'd7, 3'd2);
        step();
        @(negedge clk);
        check("t1_valid", {31'd0, o_alu_valid}, 32'd1);
        step();
        @(negedge clk);
        check("t1_empty_valid", {31'd0, o_alu_valid}, 32'd0);
        check("t1_empty_ready", {31'd0, i_iq_ready}, 32'd1);
        step();

        // T2: rs2 waits for tag 4, broadcast two cycles after dispatch
        disp(4'd2, 3'd0, 3'd4, 32'h11, 32'h0, 3'd3, 1'b0);
        expect_issue(4'd2, 32'h11, 32'h1234, 3'd3);
        step();
        @(negedge clk);
        check("t2_wait1", {31'd0, o_alu_valid}, 32'd0);
        step();
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 3'd4;
        i_cdb_data  = 32'h1234;
        @(negedge clk);
        check("t2_cdb_cycle", {31'd0, o_alu_valid}, {31'd0, BYP});
        step();
        @(negedge clk);
        check("t2_after_cdb", {31'd0, o_alu_valid}, {31'd0, ~BYP});
        step();

        // T3: same-cycle capture at dispatch
        disp(4'd3, 3'd5, 3'd0, 32'hdead, 32'd2, 3'd5, 1'b0);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 3'd5;
        i_cdb_data  = 32'd9;
        expect_issue(4'd3, 32'd9, 32'd2, 3'd5);
        step();
        @(negedge clk);
        check("t3_valid", {31'd0, o_alu_valid}, 32'd1);
        step();

        // T4: fill all four entries, no ready-through, oldest-first drain
        o_alu_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(4 + k), 3'd0, 3'd0, 32'(10 + k), 32'(20 + k), 3'(k + 1), 1'b0);
            expect_issue(4'(4 + k), 32'(10 + k), 32'(20 + k), 3'(k + 1));
            step();
        end
        @(negedge clk);
        check("t4_full_ready", {31'd0, i_iq_ready}, 32'd0);
        check("t4_oldest_tag", {29'd0, o_alu_tag}, 32'd1);
        step();
        o_alu_ready = 1'b1;
        @(negedge clk);
        check("t4_no_ready_through", {31'd0, i_iq_ready}, 32'd0);
        step();
        o_alu_ready = 1'b0;
        @(negedge clk);
        check("t4_ready_after_issue", {31'd0, i_iq_ready}, 32'd1);
        check("t4_next_tag", {29'd0, o_alu_tag}, 32'd2);
        step();
        o_alu_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t4_drained", {31'd0, o_alu_valid}, 32'd0);
        step();

        // T5: two non-spec, two spec, then mispredict flush
        o_alu_ready = 1'b0;
        disp(4'd8, 3'd0, 3'd0, 32'd100, 32'd101, 3'd1, 1'b0);
        expect_issue(4'd8, 32'd100, 32'd101, 3'd1);
        step();
        disp(4'd9, 3'd0, 3'd0, 32'd200, 32'd201, 3'd2, 1'b0);
        expect_issue(4'd9, 32'd200, 32'd201, 3'd2);
        step();
        disp(4'd10, 3'd0, 3'd0, 32'd300, 32'd301, 3'd3, 1'b1);
        step();
        disp(4'd11, 3'd0, 3'd0, 32'd400, 32'd401, 3'd4, 1'b1);
        step();
        i_branch_valid = 1'b1;
        i_branch_flush = 1'b1;
        @(negedge clk);
        check("t5_flush_full", {31'd0, i_iq_ready}, 32'd0);
        check("t5_flush_tag", {29'd0, o_alu_tag}, 32'd1);
        step();
        @(negedge clk);
        check("t5_after_flush_ready", {31'd0, i_iq_ready}, 32'd1);
        step();
        o_alu_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t5_drained", {31'd0, o_alu_valid}, 32'd0);
        step();

        // T6: spec dispatch with same-cycle correct resolution survives a later flush
        o_alu_ready = 1'b0;
        disp(4'd12, 3'd0, 3'd0, 32'd600, 32'd601, 3'd6, 1'b1);
        i_branch_valid = 1'b1;
        i_branch_flush = 1'b0;
        expect_issue(4'd12, 32'd600, 32'd601, 3'd6);
        step();
        step();
        i_branch_valid = 1'b1;
        i_branch_flush = 1'b1;
        @(negedge clk);
        check("t6_valid_in_flush", {31'd0, o_alu_valid}, 32'd1);
        check("t6_tag_in_flush", {29'd0, o_alu_tag}, 32'd6);
        step();
        o_alu_ready = 1'b1;
        repeat (2) step();

        // T7: reset mid-operation discards entries immediately
        o_alu_ready = 1'b0;
        disp(4'd13, 3'd0, 3'd0, 32'd700, 32'd701, 3'd7, 1'b0);
        step();
        @(negedge clk);
        check("t7_pending", {31'd0, o_alu_valid}, 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("t7_reset_valid", {31'd0, o_alu_valid}, 32'd0);
        check("t7_reset_ready", {31'd0, i_iq_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Bounded drain of any outstanding expectations
        o_alu_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_reservation_station.md
Name: int_reservation_station

Overview:
- Reservation station for the integer unit; sits directly downstream of the instruction queue's integer twowire output.
- Buffers renamed integer ops and snoops the common data bus (CDB) for missing operands.
- Issues the oldest fully-ready op to the integer ALU.
- Squashes speculative entries when the branch unit reports a mispredict.

Parameters:
- NUM_ENTRY, 4, number of station slots (power of two, >=2).
- BW_TAG, 3, tag width; tag 0 means "operand valid, no producer".
- BW_PROCESSOR_DATA, 32, operand width.
- BW_OPCODE_INT, 4, integer opcode width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_iq_valid  input  1  dispatch valid from instruction queue
- i_iq_ready  output  1  station can accept a dispatch
- i_iq_opcode  input  BW_OPCODE_INT  integer opcode
- i_iq_Q_flatten  input  2*BW_TAG  source tags; rs1 in low slice
- i_iq_V_flatten  input  2*BW_PROCESSOR_DATA  source values; rs1 in low slice
- i_iq_tag  input  BW_TAG  destination tag
- i_iq_speculation  input  1  op is behind an unresolved branch
- i_cdb_valid  input  1  CDB broadcast valid
- i_cdb_tag  input  BW_TAG  broadcast tag
- i_cdb_data  input  BW_PROCESSOR_DATA  broadcast value
- i_branch_valid  input  1  branch resolved this cycle
- i_branch_flush  input  1  resolution was a mispredict
- o_alu_valid  output  1  issue valid
- o_alu_ready  input  1  ALU accepts
- o_alu_opcode  output  BW_OPCODE_INT  issued opcode
- o_alu_A  output  BW_PROCESSOR_DATA  operand rs1
- o_alu_B  output  BW_PROCESSOR_DATA  operand rs2
- o_alu_tag  output  BW_TAG  issued destination tag

Behaviour:

Entry state and reset:
- Per entry: busy, opcode, Q[2], V[2], tag, spec, age rank (0 = oldest).
- Reset clears all busy bits. i_iq_ready=1 and o_alu_valid=0 after reset. o_alu_* data outputs are 0 while no entry is selected.

Dispatch:
- i_iq_ready = any entry not busy. It is independent of i_iq_valid and of the flush.
- On handshake, the lowest-index free entry is written and receives the youngest age rank.
- Same-cycle capture: if i_cdb_valid, Q[k]!=0 and Q[k]==i_cdb_tag, the stored V[k] is i_cdb_data and Q[k] is 0.
- If the dispatch is speculative and i_branch_valid&&i_branch_flush is high in the same cycle, the op is dropped and no entry is written.
- If the dispatch coincides with i_branch_valid&&!i_branch_flush, it is stored with spec=0.

Wakeup:
- Each cycle, every busy entry with Q[k]==i_cdb_tag (Q[k]!=0) and i_cdb_valid captures i_cdb_data and clears Q[k].

Issue:
- An entry is eligible when busy and both Q==0, as held in registers.
- The oldest eligible entry drives o_alu_*.
- o_alu_valid=1 when any entry is eligible, except that a speculative entry is masked while i_branch_valid&&i_branch_flush is high.
- On o_alu_valid&&o_alu_ready the entry frees at the clock edge, and all younger ranks decrement by 1.
- o_alu_valid may not drop without a handshake, except on a flush of that entry.

Branch resolution:
- i_branch_valid&&i_branch_flush: all spec=1 entries free at the edge and age ranks recompact.
- i_branch_valid&&!i_branch_flush: all spec bits clear.

Simultaneous events:
- Dispatch and issue in the same cycle are both honoured.
- When the station is full, a same-cycle issue does not make i_iq_ready=1 in that cycle; there is no combinational ready-through.
- With NUM_ENTRY entries occupied, i_iq_ready=0.
- Reset mid-operation discards all entries immediately.

Latency:
- Dispatch with ready operands: issue-eligible the next cycle.
- Operand supplied by CDB at cycle t: eligible at t+1.

Optional Feature:
- Macro RS_CDB_BYPASS_EN.
- Defined: an entry whose last missing operand matches the current CDB broadcast is eligible in the same cycle. The operand is forwarded combinationally from i_cdb_data to o_alu_A/B, so CDB-to-issue latency is 0 cycles. Oldest-first ordering still applies.
- Undefined: eligibility is taken from registered Q only, so CDB-to-issue latency is 1 cycle.

Test Plan:
- Reset, then dispatch ADD with Q={0,0}, V={5,7}, tag 2 -> next cycle o_alu_valid=1, A=5, B=7, tag=2; with o_alu_ready=1 the station is empty the following cycle.
- Dispatch op tag 3 with Q1=4, then CDB tag 4 data 0x1234 two cycles later -> issues with B=0x1234 one cycle after the broadcast (same cycle with RS_CDB_BYPASS_EN).
- Dispatch with Q0=5 while CDB broadcasts tag 5 data 9 in the same cycle -> stored operand is 9 and the op issues the next cycle.
- Fill all 4 entries with o_alu_ready=0 -> i_iq_ready=0. Release one handshake -> i_iq_ready=1 the next cycle. Issue order follows tags 1,2,3,4 as dispatched.
- Dispatch two non-spec and two spec ops, then assert branch valid+flush -> spec entries vanish, non-spec ones issue in order, and no spec tag appears on o_alu_tag.
- Dispatch a spec op with branch valid and no flush in the same cycle, then assert a later flush -> the entry survives and issues.
